// File: rtl/lpc_param_if.sv
// ---------------------------------------------------------------------------
// lpc_param_if
//   Per-frame LPC excitation parameter channel.
//
//   Handshake: a transfer happens on a rising clk edge where both
//   param_valid and param_ready are high. The master holds param_voiced,
//   param_pitch and param_gain stable while param_valid is high. The slave
//   may raise or lower param_ready at any time; it depends only on slave state.
//
//   Signals:
//     param_valid   master -> slave  frame parameters present
//     param_ready   slave  -> master slave can accept parameters
//     param_voiced  master -> slave  1 = pulse train, 0 = noise
//     param_pitch   master -> slave  pitch period in samples (unsigned)
//     param_gain    master -> slave  amplitude (unsigned)
// ---------------------------------------------------------------------------
interface lpc_param_if;
  logic        param_valid;
  logic        param_ready;
  logic        param_voiced;
  logic [15:0] param_pitch;
  logic [14:0] param_gain;

  modport master (
    output param_valid,
    output param_voiced,
    output param_pitch,
    output param_gain,
    input  param_ready
  );

  modport slave (
    input  param_valid,
    input  param_voiced,
    input  param_pitch,
    input  param_gain,
    output param_ready
  );
endinterface

// File: rtl/lpc_excitation_ctrl.sv
// ---------------------------------------------------------------------------
// lpc_excitation_ctrl
//   Frame-level excitation scheduler for the LPC synthesis path. Frame
//   parameters arrive over lpc_param_if and are double-buffered (active +
//   shadow). Samples are paced every CLKS_PER_SAMPLE clocks; each sample is a
//   gain-scaled pulse train (voiced) or gain-scaled LFSR noise (unvoiced).
//
//   Optional build macro: PITCH_JITTER_EN
//     When defined, every pitch wrap picks the next pitch interval from
//     lfsr[2:1]: 01 -> P+1 (saturating), 10 -> max(P-1,1), else P.
//
//   Ports:
//     clk          system clock, all logic on posedge
//     rst          synchronous active-high reset
//     prm          parameter channel (slave side)
//     exc_out      signed excitation sample, held between strobes
//     exc_valid    one-cycle strobe per sample
//     frame_start  high with the first exc_valid of each frame
//     underrun     one-cycle pulse when a frame boundary finds no new params
//     frame_count  frames started since reset (wraps)
//     dbg_state    current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module lpc_excitation_ctrl #(
  parameter int unsigned CLKS_PER_SAMPLE   = 4,
  parameter int unsigned SAMPLES_PER_FRAME = 160,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  lpc_param_if.slave  prm,
  output logic [15:0] exc_out,
  output logic        exc_valid,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] frame_count,
  output logic        dbg_state
);

  localparam int unsigned DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int unsigned IDX_W = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_FRAME - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
  logic [15:0]      pitch_cnt_q, pitch_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             act_voiced_q, act_voiced_d;
  logic [15:0]      act_pitch_q, act_pitch_d;
  logic [14:0]      act_gain_q, act_gain_d;

  logic             shd_full_q, shd_full_d;
  logic             shd_voiced_q, shd_voiced_d;
  logic [15:0]      shd_pitch_q, shd_pitch_d;
  logic [14:0]      shd_gain_q, shd_gain_d;

  logic [15:0]      exc_out_q, exc_out_d;
  logic             exc_valid_q, exc_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      frame_count_q, frame_count_d;

`ifdef PITCH_JITTER_EN
  logic [1:0]       jitter_sel_q, jitter_sel_d;
`endif

  logic        xfer;
  logic        tick;
  logic [15:0] pitch_p;
  logic [15:0] interval;
  logic        pitch_wrap;
  logic        lfsr_fb;
  logic [15:0] gain_pos;
  logic [15:0] gain_neg;

  // Ready depends on state only, so the master sees a stable value all cycle.
  assign prm.param_ready = (state_q == S_IDLE) ? 1'b1 : !shd_full_q;
  assign xfer            = prm.param_valid && prm.param_ready;
  assign tick            = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);

  // A pitch of 0 behaves as 1 (a pulse on every sample).
  assign pitch_p = (act_pitch_q == 16'd0) ? 16'd1 : act_pitch_q;

`ifdef PITCH_JITTER_EN
  always_comb begin
    interval = pitch_p;
    case (jitter_sel_q)
      2'b01:   interval = (pitch_p == 16'hFFFF) ? 16'hFFFF : pitch_p + 16'd1;
      2'b10:   interval = (pitch_p > 16'd1) ? pitch_p - 16'd1 : 16'd1;
      default: interval = pitch_p;
    endcase
  end
`else
  assign interval = pitch_p;
`endif

  // >= rather than == so a shrinking period wraps the counter immediately.
  assign pitch_wrap = (pitch_cnt_q >= (interval - 16'd1));

  // Fibonacci taps 16,14,13,11 map to bits 0,2,3,5 in a right-shifting register.
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign gain_pos = {1'b0, act_gain_q};
  assign gain_neg = (~gain_pos) + 16'd1;

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    sample_idx_d  = sample_idx_q;
    pitch_cnt_d   = pitch_cnt_q;
    lfsr_d        = lfsr_q;
    act_voiced_d  = act_voiced_q;
    act_pitch_d   = act_pitch_q;
    act_gain_d    = act_gain_q;
    shd_full_d    = shd_full_q;
    shd_voiced_d  = shd_voiced_q;
    shd_pitch_d   = shd_pitch_q;
    shd_gain_d    = shd_gain_q;
    exc_out_d     = exc_out_q;
    exc_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    frame_count_d = frame_count_q;
`ifdef PITCH_JITTER_EN
    jitter_sel_d  = jitter_sel_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          act_voiced_d = prm.param_voiced;
          act_pitch_d  = prm.param_pitch;
          act_gain_d   = prm.param_gain;
          div_cnt_d    = '0;
          sample_idx_d = '0;
          pitch_cnt_d  = '0;
`ifdef PITCH_JITTER_EN
          jitter_sel_d = 2'b00;
`endif
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        if (tick) begin
          div_cnt_d   = '0;
          exc_valid_d = 1'b1;
          if (act_voiced_q) begin
            exc_out_d = (pitch_cnt_q == 16'd0) ? gain_pos : 16'd0;
          end else begin
            exc_out_d = lfsr_q[0] ? gain_pos : gain_neg;
          end

          pitch_cnt_d = pitch_wrap ? 16'd0 : pitch_cnt_q + 16'd1;
`ifdef PITCH_JITTER_EN
          if (pitch_wrap) begin
            jitter_sel_d = lfsr_q[2:1];
          end
`endif
          lfsr_d = {lfsr_fb, lfsr_q[15:1]};

          if (sample_idx_q == '0) begin
            frame_start_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end

          if (sample_idx_q == IDX_LAST) begin
            sample_idx_d = '0;
            if (shd_full_q) begin
              act_voiced_d = shd_voiced_q;
              act_pitch_d  = shd_pitch_q;
              act_gain_d   = shd_gain_q;
              shd_full_d   = 1'b0;
            end else begin
              // Active parameters repeat; a same-edge write lands in the
              // shadow below and is used from the next boundary.
              underrun_d = 1'b1;
            end
          end else begin
            sample_idx_d = sample_idx_q + IDX_ONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end

        // xfer in RUN implies the shadow was empty, so it never collides with
        // the shadow-to-active move above.
        if (xfer) begin
          shd_voiced_d = prm.param_voiced;
          shd_pitch_d  = prm.param_pitch;
          shd_gain_d   = prm.param_gain;
          shd_full_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      sample_idx_q  <= '0;
      pitch_cnt_q   <= '0;
      lfsr_q        <= LFSR_SEED;
      act_voiced_q  <= 1'b0;
      act_pitch_q   <= '0;
      act_gain_q    <= '0;
      shd_full_q    <= 1'b0;
      shd_voiced_q  <= 1'b0;
      shd_pitch_q   <= '0;
      shd_gain_q    <= '0;
      exc_out_q     <= '0;
      exc_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      frame_count_q <= '0;
`ifdef PITCH_JITTER_EN
      jitter_sel_q  <= 2'b00;
`endif
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      sample_idx_q  <= sample_idx_d;
      pitch_cnt_q   <= pitch_cnt_d;
      lfsr_q        <= lfsr_d;
      act_voiced_q  <= act_voiced_d;
      act_pitch_q   <= act_pitch_d;
      act_gain_q    <= act_gain_d;
      shd_full_q    <= shd_full_d;
      shd_voiced_q  <= shd_voiced_d;
      shd_pitch_q   <= shd_pitch_d;
      shd_gain_q    <= shd_gain_d;
      exc_out_q     <= exc_out_d;
      exc_valid_q   <= exc_valid_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      frame_count_q <= frame_count_d;
`ifdef PITCH_JITTER_EN
      jitter_sel_q  <= jitter_sel_d;
`endif
    end
  end

  assign exc_out     = exc_out_q;
  assign exc_valid   = exc_valid_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;

endmodule
